sd_spi_card_responder: RTL and testbench

// - Synthesizable SPI-mode SD card responder: the card end of the link driven by SD_TOP's init/command engine.
// - Oversamples SD_CK on clk, receives 48-bit command frames on SD_MOSI and returns R1/R3/R7 responses on SD_MISO.
// - Tracks card power-up/idle state so the host init sequence CMD0→CMD8→(CMD55+ACMD41)*→CMD58 runs to completion.

---
 rtl/sd_spi_card_responder.sv | 218 +++++++++++++++++++++
 tb/tb_sd_spi_card_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_card_responder.sv
// SPI-mode SD card responder: oversamples SD_CK on clk, decodes 48-bit
// command frames from SD_MOSI and returns R1/R3/R7 responses on SD_MISO.
// Build option: define SD_CRC7_CHECK_EN to validate the CRC7 and end bit of
// each frame. Without it, the CRC byte is ignored.
module sd_spi_card_responder #(
  parameter int unsigned N_NCR        = 1,
  parameter int unsigned INIT_RETRIES = 3,
  parameter logic [31:0] OCR_VALUE    = 32'hC0FF8000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SD_CK,
  input  logic       SD_MOSI,
  output logic       SD_MISO,
  output logic       card_idle,
  output logic       cmd_valid,
  output logic [5:0] cmd_index
);

  typedef enum logic [2:0] {HUNT, RX, DECODE, NCR, TX} state_t;

  localparam logic [6:0] NCR_LAST = 7'(N_NCR * 8 - 1);
  localparam logic [7:0] RETRIES  = 8'(INIT_RETRIES);

  state_t      state, state_next;
  logic [1:0]  ck_sync, mosi_sync;
  logic        ck_prev;
  logic        rise, fall, mosi_bit;
  logic [47:0] frame;
  logic [5:0]  bit_cnt, tx_cnt, tx_len;
  logic [6:0]  ncr_cnt;
  logic [39:0] resp_sr;
  logic        app_cmd;
  logic [7:0]  acmd41_cnt;

  logic [5:0]  idx;
  logic [31:0] arg;
  logic        crc_ok;
  logic [39:0] dec_resp;
  logic [5:0]  dec_len;
  logic        dec_idle, dec_app;
  logic [7:0]  dec_cnt;
  logic        unused_frame_bits;

  assign rise     = ck_sync[1] & ~ck_prev;
  assign fall     = ~ck_sync[1] & ck_prev;
  assign mosi_bit = mosi_sync[1];
  assign idx      = frame[45:40];
  assign arg      = frame[39:8];
  assign unused_frame_bits = ^{frame[47:46], arg[31:12], frame[7:0]};

`ifdef SD_CRC7_CHECK_EN
  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0]  c;
    logic [39:0] d;
    logic        fb;
    c = '0;
    d = data;
    for (int unsigned i = 0; i < 40; i++) begin
      fb = c[6] ^ d[39];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
      d  = {d[38:0], 1'b0};
    end
    return c;
  endfunction
`endif

  // Two-flop synchronizers for the host clock and data, plus edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_sync   <= '0;
      mosi_sync <= '1;
      ck_prev   <= 1'b0;
    end else begin
      ck_sync   <= {ck_sync[0], SD_CK};
      mosi_sync <= {mosi_sync[0], SD_MOSI};
      ck_prev   <= ck_sync[1];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      HUNT:    if (rise && !mosi_bit) state_next = RX;
      RX: begin
        if (rise) begin
          if (bit_cnt == 6'd1 && !mosi_bit) state_next = HUNT;
          else if (bit_cnt == 6'd47)        state_next = DECODE;
        end
      end
      DECODE:  state_next = NCR;
      NCR:     if (fall && ncr_cnt == NCR_LAST) state_next = TX;
      TX:      if (fall && tx_cnt == tx_len) state_next = HUNT;
      default: state_next = HUNT;
    endcase
  end

  // Command decode: response selection and card-state update for the held frame
  always_comb begin
    dec_idle = card_idle;
    dec_app  = 1'b0;
    dec_cnt  = acmd41_cnt;
    dec_len  = 6'd8;
    dec_resp = '0;
`ifdef SD_CRC7_CHECK_EN
    crc_ok   = (crc7(frame[47:8]) == frame[7:1]) && frame[0];
`else
    crc_ok   = 1'b1;
`endif
    if (!crc_ok) begin
      dec_app        = app_cmd;
      dec_resp[39:32] = {4'b0000, 1'b1, 2'b00, card_idle};
    end else begin
      case (idx)
        6'd0: begin
          dec_idle        = 1'b1;
          dec_cnt         = '0;
          dec_resp[39:32] = 8'h01;
        end
        6'd8: begin
          dec_resp = {7'b0, card_idle, 20'h0, arg[11:0]};
          dec_len  = 6'd40;
        end
        6'd55: begin
          dec_app         = 1'b1;
          dec_resp[39:32] = {7'b0, card_idle};
        end
        6'd41: begin
          if (app_cmd) begin
            if (acmd41_cnt < RETRIES) dec_cnt = acmd41_cnt + 8'd1;
            if (dec_cnt >= RETRIES)   dec_idle = 1'b0;
            dec_resp[39:32] = {7'b0, dec_idle};
          end else begin
            dec_resp[39:32] = {5'b0, 1'b1, 1'b0, card_idle};
          end
        end
        6'd58: begin
          dec_resp = {7'b0, card_idle, OCR_VALUE};
          dec_len  = 6'd40;
        end
        default: dec_resp[39:32] = {5'b0, 1'b1, 1'b0, card_idle};
      endcase
    end
  end

  // Frame capture, card state, NCR fill and response shift-out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SD_MISO    <= 1'b1;
      card_idle  <= 1'b1;
      cmd_valid  <= 1'b0;
      cmd_index  <= '0;
      app_cmd    <= 1'b0;
      acmd41_cnt <= '0;
      frame      <= '0;
      bit_cnt    <= '0;
      ncr_cnt    <= '0;
      tx_cnt     <= '0;
      tx_len     <= 6'd8;
      resp_sr    <= '0;
    end else begin
      cmd_valid <= 1'b0;
      case (state)
        HUNT: begin
          if (rise && !mosi_bit) begin
            frame   <= {frame[46:0], 1'b0};
            bit_cnt <= 6'd1;
          end
        end
        RX: begin
          if (rise) begin
            frame   <= {frame[46:0], mosi_bit};
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        DECODE: begin
          cmd_valid  <= 1'b1;
          cmd_index  <= idx;
          card_idle  <= dec_idle;
          app_cmd    <= dec_app;
          acmd41_cnt <= dec_cnt;
          resp_sr    <= dec_resp;
          tx_len     <= dec_len;
          ncr_cnt    <= '0;
          tx_cnt     <= '0;
          SD_MISO    <= 1'b1;
        end
        NCR: begin
          if (fall) begin
            ncr_cnt <= ncr_cnt + 7'd1;
            SD_MISO <= 1'b1;
          end
        end
        TX: begin
          if (fall) begin
            if (tx_cnt == tx_len) begin
              SD_MISO <= 1'b1;
            end else begin
              SD_MISO <= resp_sr[39];
              resp_sr <= {resp_sr[38:0], 1'b0};
              tx_cnt  <= tx_cnt + 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Bench for sd_spi_card_responder: an SPI host drives command frames, a
// reference model of the card predicts each response into a scoreboard, and
// a monitor process compares captured responses and cmd_valid pulses.
module tb_sd_spi_card_responder;

  localparam int unsigned NCR     = 2;
  localparam int unsigned RETRIES = 3;
  localparam logic [31:0] OCR     = 32'hC0FF8000;
  localparam int          HALF    = 4;
`ifdef SD_CRC7_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       SD_CK = 1'b0;
  logic       SD_MOSI = 1'b1;
  logic       SD_MISO;
  logic       card_idle;
  logic       cmd_valid;
  logic [5:0] cmd_index;

  always #5 clk = ~clk;

  sd_spi_card_responder #(
    .N_NCR(NCR),
    .INIT_RETRIES(RETRIES),
    .OCR_VALUE(OCR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .SD_CK(SD_CK),
    .SD_MOSI(SD_MOSI),
    .SD_MISO(SD_MISO),
    .card_idle(card_idle),
    .cmd_valid(cmd_valid),
    .cmd_index(cmd_index)
  );

  typedef struct {
    logic [39:0] resp;
    int          len;
    logic        ncr_ok;
    logic        trail_ok;
    logic        idle;
  } xfer_t;

  xfer_t      exp_q[$];
  xfer_t      got_q[$];
  logic [5:0] idx_q[$];

  int total = 0;
  int bad   = 0;

  // Card model state
  bit m_idle = 1'b1;
  bit m_app  = 1'b0;
  int m_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [7:0] good_crc(input logic [5:0] idx, input logic [31:0] arg);
    return {crc7({2'b01, idx, arg}), 1'b1};
  endfunction

  // Card behaviour: what the response is and how the card state moves
  function automatic void model(input logic [5:0] idx, input logic [31:0] arg,
                                input logic [7:0] crcb, output logic [39:0] r, output int len);
    logic [7:0] r1;
    bit         acmd;
    bit         legal;
    len = 8;
    if (CRC_EN && crcb != good_crc(idx, arg)) begin
      r = {8'h08 | {7'd0, m_idle}, 32'h0};
      return;
    end
    acmd  = m_app;
    m_app = (idx == 6'd55);
    legal = 1'b1;
    case (idx)
      6'd0: begin m_idle = 1'b1; m_cnt = 0; end
      6'd8, 6'd55, 6'd58: ;
      6'd41: begin
        if (acmd) begin
          if (m_cnt < int'(RETRIES)) m_cnt++;
          if (m_cnt >= int'(RETRIES)) m_idle = 1'b0;
        end else legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    r1 = {7'd0, m_idle} | (legal ? 8'h00 : 8'h04);
    if (idx == 6'd8) begin
      r = {r1, 20'h0, arg[11:0]}; len = 40;
    end else if (idx == 6'd58) begin
      r = {r1, OCR}; len = 40;
    end else begin
      r = {r1, 32'h0};
    end
  endfunction

  // One SPI bit: MOSI set while SCK low, MISO sampled just before the rise
  task automatic bit_cycle(input logic mosi, output logic miso);
    SD_MOSI = mosi;
    repeat (HALF) @(posedge clk);
    #1;
    miso  = SD_MISO;
    SD_CK = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
    SD_CK = 1'b0;
  endtask

  task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg,
                        input logic [7:0] crcb, input int abort_at);
    logic [47:0] fr;
    xfer_t       e, g;
    logic        b;
    fr = {2'b01, idx, arg, crcb};
    model(idx, arg, crcb, e.resp, e.len);
    e.ncr_ok   = 1'b1;
    e.trail_ok = 1'b1;
    e.idle     = m_idle;
    idx_q.push_back(idx);
    if (abort_at == 0) exp_q.push_back(e);
    for (int i = 47; i >= 0; i--) bit_cycle(fr[i], b);
    g.ncr_ok = 1'b1;
    for (int i = 0; i < int'(NCR) * 8; i++) begin
      bit_cycle(1'b1, b);
      if (b !== 1'b1) g.ncr_ok = 1'b0;
    end
    g.resp = '0;
    g.len  = e.len;
    for (int i = 0; i < e.len; i++) begin
      bit_cycle(1'b1, b);
      g.resp[39-i] = b;
      if (abort_at > 0 && i + 1 == abort_at) break;
    end
    if (abort_at > 0) begin
      repeat (4) @(posedge clk);
      #1;
      check("abort_pre_miso", 64'(SD_MISO), 64'(e.resp[39-abort_at]));
      check("abort_pre_idle", 64'(card_idle), 64'(m_idle));
      rst_n = 1'b0;
      #1;
      check("abort_rst_miso", 64'(SD_MISO), 64'd1);
      check("abort_rst_idle", 64'(card_idle), 64'd1);
      check("abort_rst_index", 64'(cmd_index), 64'd0);
      repeat (4) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      m_idle = 1'b1;
      m_app  = 1'b0;
      m_cnt  = 0;
      return;
    end
    g.trail_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bit_cycle(1'b1, b);
      if (b !== 1'b1) g.trail_ok = 1'b0;
    end
    g.idle = card_idle;
    got_q.push_back(g);
  endtask

  // Monitor: compares cmd_valid pulses and completed responses to the scoreboard
  initial begin
    xfer_t g, e;
    logic [5:0] ei;
    forever begin
      @(negedge clk);
      if (rst_n && cmd_valid) begin
        if (idx_q.size() == 0) begin
          check("cmd_valid_unexpected", 64'(cmd_index), 64'h40);
        end else begin
          ei = idx_q.pop_front();
          check("cmd_index", 64'(cmd_index), 64'(ei));
        end
      end
      if (got_q.size() > 0) begin
        g = got_q.pop_front();
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 64'(g.resp), 64'hFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("resp", 64'(g.resp), 64'(e.resp));
          check("ncr_fill", 64'(g.ncr_ok), 64'(e.ncr_ok));
          check("trail_idle", 64'(g.trail_ok), 64'(e.trail_ok));
          check("card_idle", 64'(g.idle), 64'(e.idle));
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        b, ok;
    logic [5:0]  ridx;
    logic [31:0] rarg;
    logic [7:0]  rcrc;
    int          sel, wait_cnt;

    repeat (5) @(posedge clk);
    #1;
    check("rst_miso", 64'(SD_MISO), 64'd1);
    check("rst_idle", 64'(card_idle), 64'd1);
    check("rst_valid", 64'(cmd_valid), 64'd0);
    check("rst_index", 64'(cmd_index), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    if (CRC_EN) do_cmd(6'd0, 32'h0, 8'h94, 0);
    do_cmd(6'd0, 32'h0, 8'h95, 0);
    do_cmd(6'd8, 32'h000001AA, 8'h87, 0);
    for (int i = 0; i < int'(RETRIES); i++) begin
      do_cmd(6'd55, 32'h0, 8'h65, 0);
      do_cmd(6'd41, 32'h40000000, 8'h77, 0);
    end
    do_cmd(6'd58, 32'h0, 8'hFD, 0);
    do_cmd(6'd17, 32'h0, 8'h55, 0);
    do_cmd(6'd41, 32'h0, good_crc(6'd41, 32'h0), 0);

    // Frame with transmission bit 0 must be dropped silently
    bit_cycle(1'b0, b);
    bit_cycle(1'b0, b);
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bit_cycle(1'b1, b);
      if (b !== 1'b1) ok = 1'b0;
    end
    check("discard_miso_idle", 64'(ok), 64'd1);

    // Reset in the middle of an R7 response, then a clean CMD0
    do_cmd(6'd8, 32'h000001AA, 8'h87, 3);
    do_cmd(6'd0, 32'h0, 8'h95, 0);

    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0:       ridx = 6'd0;
        1:       ridx = 6'd8;
        2, 3:    ridx = 6'd55;
        4, 5:    ridx = 6'd41;
        6:       ridx = 6'd58;
        default: ridx = 6'($urandom);
      endcase
      rarg = $urandom;
      rcrc = good_crc(ridx, rarg);
      if ($urandom_range(0, 5) == 0) rcrc = rcrc ^ (8'd1 << $urandom_range(0, 7));
      do_cmd(ridx, rarg, rcrc, 0);
    end

    wait_cnt = 0;
    while ((got_q.size() > 0 || idx_q.size() > 0) && wait_cnt < 200) begin
      @(posedge clk);
      wait_cnt++;
    end
    check("drain_responses", 64'(got_q.size()), 64'd0);
    check("drain_cmd_pulses", 64'(idx_q.size()), 64'd0);
    check("drain_expected", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
